mem_access_unit: RTL

// - Memory stage directly downstream of the ALU: consumes ALU_result as the effective address (loads/stores) or as pass-through result (R-type).
// - Drives a req/ack data-memory port, forms byte enables, lane-aligns store data, sign/zero-extends load data.
// - Emits one registered writeback record per accepted op; backpressures the ALU via ex_ready while a memory access is outstanding.

---
 rtl/mem_pkg.sv | 61 ++++++
 rtl/mem_access_unit_if.sv | 43 ++++
 rtl/lsu_load_align.sv | 28 ++
 rtl/mem_access_unit.sv | 118 +++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared funct3 codes, FSM state type, latched-op record and access-shaping helpers
// for the memory access unit.
package mem_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned F3_WIDTH = 3;
    localparam int unsigned RD_WIDTH = 5;
    localparam int unsigned BE_WIDTH = XLEN / 8;

    localparam logic [F3_WIDTH-1:0] F3_B  = 3'b000;
    localparam logic [F3_WIDTH-1:0] F3_H  = 3'b001;
    localparam logic [F3_WIDTH-1:0] F3_W  = 3'b010;
    localparam logic [F3_WIDTH-1:0] F3_BU = 3'b100;
    localparam logic [F3_WIDTH-1:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    // Op context kept while the memory access is outstanding.
    typedef struct packed {
        logic                is_load;
        logic [F3_WIDTH-1:0] f3;
        logic [1:0]          addr_lo;
        logic [RD_WIDTH-1:0] rd;
    } mem_op_t;

    function automatic logic f3_legal(input logic is_store, input logic [F3_WIDTH-1:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return ~is_store;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [F3_WIDTH-1:0] f3, input logic [1:0] a);
        case (f3)
            F3_H, F3_HU: return a[0];
            F3_W:        return a != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic [BE_WIDTH-1:0] calc_be(input logic [F3_WIDTH-1:0] f3, input logic [1:0] a);
        case (f3)
            F3_B, F3_BU: return 4'b0001 << a;
            F3_H, F3_HU: return a[1] ? 4'b1100 : 4'b0011;
            default:     return 4'b1111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] calc_wdata(input logic [F3_WIDTH-1:0] f3, input logic [XLEN-1:0] d);
        case (f3)
            F3_B:    return {4{d[7:0]}};
            F3_H:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bundle of the ALU-side handshake, data-memory port and writeback record of the
// memory access unit. master = surrounding pipeline/memory, slave = the unit.
interface mem_access_unit_if;
    import mem_pkg::*;

    logic                ex_valid;
    logic                ex_ready;
    logic                mem_read;
    logic                mem_write;
    logic [F3_WIDTH-1:0] funct3;
    logic [XLEN-1:0]     alu_result;
    logic [XLEN-1:0]     store_data;
    logic [RD_WIDTH-1:0] rd;

    logic                dmem_req;
    logic                dmem_we;
    logic [XLEN-1:0]     dmem_addr;
    logic [BE_WIDTH-1:0] dmem_be;
    logic [XLEN-1:0]     dmem_wdata;
    logic                dmem_ack;
    logic [XLEN-1:0]     dmem_rdata;

    logic                wb_valid;
    logic                wb_we;
    logic [RD_WIDTH-1:0] wb_rd;
    logic [XLEN-1:0]     wb_data;
    logic                wb_err;

    modport master (
        output ex_valid, mem_read, mem_write, funct3, alu_result, store_data, rd,
        output dmem_ack, dmem_rdata,
        input  ex_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  wb_valid, wb_we, wb_rd, wb_data, wb_err
    );

    modport slave (
        input  ex_valid, mem_read, mem_write, funct3, alu_result, store_data, rd,
        input  dmem_ack, dmem_rdata,
        output ex_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output wb_valid, wb_we, wb_rd, wb_data, wb_err
    );

endinterface

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half lane of a read word and sign- or zero-extends it.
module lsu_load_align
    import mem_pkg::*;
(
    input  logic [XLEN-1:0]     rdata,
    input  logic [1:0]          addr_lo,
    input  logic [F3_WIDTH-1:0] funct3,
    output logic [XLEN-1:0]     ld_value_c
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    assign byte_c = rdata[{addr_lo, 3'b000} +: 8];
    assign half_c = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        ld_value_c = rdata;
        case (funct3)
            F3_B:    ld_value_c = {{24{byte_c[7]}}, byte_c};
            F3_BU:   ld_value_c = {24'h0, byte_c};
            F3_H:    ld_value_c = {{16{half_c[15]}}, half_c};
            F3_HU:   ld_value_c = {16'h0, half_c};
            default: ld_value_c = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: req/ack data-memory access with timeout and one writeback record per op.
// Define MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of aligning them.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input logic              clk,
    input logic              rst_n,
    mem_access_unit_if.slave bus
);

    localparam int unsigned     CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t          state;
    logic [CNT_W-1:0] cnt;
    mem_op_t         op_q;
    logic            is_mem_c;
    logic            illegal_c;
    logic [XLEN-1:0] ld_value_c;

    assign is_mem_c = bus.mem_read | bus.mem_write;

`ifdef MISALIGN_TRAP_EN
    assign illegal_c = (bus.mem_read & bus.mem_write)
                     | ~f3_legal(bus.mem_write, bus.funct3)
                     | misaligned(bus.funct3, bus.alu_result[1:0]);
`else
    assign illegal_c = (bus.mem_read & bus.mem_write)
                     | ~f3_legal(bus.mem_write, bus.funct3);
`endif

    lsu_load_align u_load_align (
        .rdata      (bus.dmem_rdata),
        .addr_lo    (op_q.addr_lo),
        .funct3     (op_q.f3),
        .ld_value_c (ld_value_c)
    );

    // Single FSM: accept in IDLE, hold the request in REQ until ack or timeout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            op_q           <= '0;
            bus.ex_ready   <= 1'b1;
            bus.dmem_req   <= 1'b0;
            bus.dmem_we    <= 1'b0;
            bus.dmem_addr  <= '0;
            bus.dmem_be    <= '0;
            bus.dmem_wdata <= '0;
            bus.wb_valid   <= 1'b0;
            bus.wb_we      <= 1'b0;
            bus.wb_rd      <= '0;
            bus.wb_data    <= '0;
            bus.wb_err     <= 1'b0;
        end else begin
            bus.wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.ex_valid) begin
                        if (!is_mem_c) begin
                            bus.wb_valid <= 1'b1;
                            bus.wb_we    <= 1'b1;
                            bus.wb_err   <= 1'b0;
                            bus.wb_rd    <= bus.rd;
                            bus.wb_data  <= bus.alu_result;
                        end else if (illegal_c) begin
                            bus.wb_valid <= 1'b1;
                            bus.wb_we    <= 1'b0;
                            bus.wb_err   <= 1'b1;
                            bus.wb_rd    <= bus.rd;
                        end else begin
                            state          <= REQ;
                            cnt            <= '0;
                            bus.ex_ready   <= 1'b0;
                            bus.dmem_req   <= 1'b1;
                            bus.dmem_we    <= bus.mem_write;
                            bus.dmem_addr  <= {bus.alu_result[XLEN-1:2], 2'b00};
                            bus.dmem_be    <= calc_be(bus.funct3, bus.alu_result[1:0]);
                            bus.dmem_wdata <= calc_wdata(bus.funct3, bus.store_data);
                            op_q           <= '{is_load: bus.mem_read, f3: bus.funct3,
                                                addr_lo: bus.alu_result[1:0], rd: bus.rd};
                        end
                    end
                end
                REQ: begin
                    // Ack in the final counted cycle still retires normally.
                    if (bus.dmem_ack) begin
                        state        <= IDLE;
                        bus.ex_ready <= 1'b1;
                        bus.dmem_req <= 1'b0;
                        bus.wb_valid <= 1'b1;
                        bus.wb_we    <= op_q.is_load;
                        bus.wb_err   <= 1'b0;
                        bus.wb_rd    <= op_q.rd;
                        if (op_q.is_load) begin
                            bus.wb_data <= ld_value_c;
                        end
                    end else if (cnt == CNT_LAST) begin
                        state        <= IDLE;
                        bus.ex_ready <= 1'b1;
                        bus.dmem_req <= 1'b0;
                        bus.wb_valid <= 1'b1;
                        bus.wb_we    <= 1'b0;
                        bus.wb_err   <= 1'b1;
                        bus.wb_rd    <= op_q.rd;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
